spi_master_arb: RTL and testbench
=================================

# spi_master_arb

Round-robin arbiter and sequencer sharing the single SPI master engine between `NREQ` requesters, e.g. the host register bank and autonomous slot pollers. It accepts one transfer request at a time and latches that requester's configuration (length, chip select, clock divider, mode, bit order). It drives the configuration onto the master's config inputs, issues the start strobe, tracks completion through the master's `idle` flag, and returns the received word to the winning requester.

## Interface
- `NREQ`, 2: number of requesters (2..8)
- `DATA_W`, 16: transfer data width
- `LEN_W`, 5: length field width; length is encoded as bits-1
- `CS_W`, 4: chip-select mask width
- `DIV_W`, 8: clock divider width
- `SETUP_CYC`, 2: config settle cycles before start (≥1)
- `TIMEOUT`, 4096: watchdog limit in sys_clk cycles
- `sys_clk`  in  1  system clock
- `sys_rst_n`  in  1  reset; synchronous, active-low
- `req_valid`  in  NREQ  per-requester request
- `req_ready`  out  NREQ  one-hot accept strobe
- `req_wdata`  in  NREQ*DATA_W  tx word, requester i at slice i
- `req_len`  in  NREQ*LEN_W  bits-1
- `req_cs`  in  NREQ*CS_W  active chip selects
- `req_div`  in  NREQ*DIV_W  clock divider
- `req_mode`  in  NREQ*3  {lsb_first, cpha, cpol}
- `resp_valid`  out  NREQ  one-hot completion strobe
- `resp_rdata`  out  DATA_W  rx word, valid with `resp_valid`
- `resp_err`  out  1  timeout flag, valid with `resp_valid`
- `m_len`, `m_cs`, `m_div`, `m_mode`, `m_wdata`  out  LEN_W/CS_W/DIV_W/3/DATA_W  master config and tx word
- `m_start`  out  1  one-cycle start strobe
- `m_idle`  in  1  master idle
- `m_rdata`  in  DATA_W  master rx word
- `busy`  out  1  high whenever state ≠ IDLE

## Operation
- States: IDLE → CFG → START → WAIT_BUSY → WAIT_DONE → RESP → IDLE.
- IDLE: if any `req_valid`, the grant goes to the first set bit searching upward from `last+1` (mod NREQ). `req_ready[grant]` is driven combinationally in the same cycle. All fields of the granted requester are latched. Next state is CFG.
- CFG: `m_*` config outputs come from the latched registers and stay stable until RESP ends. The block counts `SETUP_CYC` cycles, then moves to START.
- START: waits for `m_idle`=1, then `m_start`=1 for exactly one cycle and moves to WAIT_BUSY.
- WAIT_BUSY: waits for `m_idle`=0 (master accepted), then moves to WAIT_DONE.
- WAIT_DONE: on `m_idle`=1, `m_rdata` is captured into `resp_rdata` and the state moves to RESP.
- RESP: `resp_valid[grant]`=1 for one cycle. `last` ← grant. Next state is IDLE.
- Requests are never aborted or preempted; there is one outstanding transfer at a time.
- `req_valid` deasserted after grant has no effect. A requester holding `req_valid` after `resp_valid` is re-arbitrated normally.
- With a single requester active, back-to-back grants go to that same requester.
- Reset values: state IDLE, `last`=NREQ-1 (so requester 0 wins first), all outputs 0, `m_*` 0.
- Reset asserted mid-transfer: the block returns to IDLE next edge with no `resp_valid`. The master is reset by the same reset.

## Timing
- Grant to first `m_start`: `SETUP_CYC`+1 cycles when `m_idle` is already high.
- Fixed overhead outside the master transfer: 1 (grant) + `SETUP_CYC` + 1 (start) + 1 (RESP).
- `resp_valid` is asserted the cycle after `m_idle` rises in WAIT_DONE.
- Minimum gap from `resp_valid` to the next `req_ready` is 1 cycle (IDLE).
- `resp_rdata`/`resp_err` hold their value until the next RESP.

## Configuration
- `SPI_ARB_TIMEOUT_EN` defined:
  - A counter runs in START, WAIT_BUSY and WAIT_DONE, cleared on entry to START.
  - On reaching `TIMEOUT`, the block goes to RESP with `resp_err`=1 and `resp_rdata`=0.
  - `m_start` is not reissued.
- Undefined: no counter, `resp_err` tied 0, and waits are unbounded.

## Test plan
- Single request: req0 wdata=0xAA55, len=15, cs=0x1, div=4, mode=0; model echoes the previous word. Required: `m_start` pulse 3 cycles after grant, `m_cs`=0x1, `m_div`=4, `resp_valid`=01, `resp_rdata`=previous word.
- Simultaneous req0+req1 held continuously for 4 transfers: grants alternate 0,1,0,1 starting with 0; `resp_valid` one-hot matches each grant.
- Config isolation: req0 div=4 cpol=0, req1 div=8 cpol=1 lsb=1. Required: `m_div`/`m_mode` switch exactly at each grant and stay stable through the transfer.
- `m_idle` held low at grant for 10 cycles: no `m_start` until `m_idle`=1, then exactly one pulse.
- Reset pulse during WAIT_DONE: `busy`=0 next cycle, no `resp_valid`, and a fresh request afterwards completes normally.
- With `SPI_ARB_TIMEOUT_EN` and TIMEOUT=64, `m_idle` stuck low after start: `resp_valid` after 64 cycles with `resp_err`=1 and `resp_rdata`=0x0000.

Source files
------------

// File: rtl/spi_master_arb_if.sv
// Bundle of requester-side and SPI-engine-side signals for spi_master_arb.
// The arbiter connects through modport master; the requesters plus engine use modport slave.
interface spi_master_arb_if #(
  parameter int NREQ   = 2,
  parameter int DATA_W = 16,
  parameter int LEN_W  = 5,
  parameter int CS_W   = 4,
  parameter int DIV_W  = 8
);
  logic [NREQ-1:0]        req_valid;
  logic [NREQ-1:0]        req_ready;
  logic [NREQ*DATA_W-1:0] req_wdata;
  logic [NREQ*LEN_W-1:0]  req_len;
  logic [NREQ*CS_W-1:0]   req_cs;
  logic [NREQ*DIV_W-1:0]  req_div;
  logic [NREQ*3-1:0]      req_mode;
  logic [NREQ-1:0]        resp_valid;
  logic [DATA_W-1:0]      resp_rdata;
  logic                   resp_err;
  logic [LEN_W-1:0]       m_len;
  logic [CS_W-1:0]        m_cs;
  logic [DIV_W-1:0]       m_div;
  logic [2:0]             m_mode;
  logic [DATA_W-1:0]      m_wdata;
  logic                   m_start;
  logic                   m_idle;
  logic [DATA_W-1:0]      m_rdata;
  logic                   busy;

  modport master (
    input  req_valid, req_wdata, req_len, req_cs, req_div, req_mode, m_idle, m_rdata,
    output req_ready, resp_valid, resp_rdata, resp_err,
           m_len, m_cs, m_div, m_mode, m_wdata, m_start, busy
  );

  modport slave (
    output req_valid, req_wdata, req_len, req_cs, req_div, req_mode, m_idle, m_rdata,
    input  req_ready, resp_valid, resp_rdata, resp_err,
           m_len, m_cs, m_div, m_mode, m_wdata, m_start, busy
  );
endinterface

// File: rtl/spi_master_arb.sv
// Round-robin arbiter/sequencer sharing one SPI master engine between NREQ requesters.
// Optional watchdog on the engine handshake is enabled by defining SPI_ARB_TIMEOUT_EN.
module spi_master_arb #(
  parameter int NREQ      = 2,
  parameter int DATA_W    = 16,
  parameter int LEN_W     = 5,
  parameter int CS_W      = 4,
  parameter int DIV_W     = 8,
  parameter int SETUP_CYC = 2,
  parameter int TIMEOUT   = 4096
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  spi_master_arb_if.master  bus
);

  localparam int GW = $clog2(NREQ);
  localparam int SW = $clog2(SETUP_CYC + 1);

  if (NREQ < 2 || NREQ > 8 || SETUP_CYC < 1 || TIMEOUT < 1) begin : g_param_check
    $error("spi_master_arb: parameter out of range");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_CFG,
    S_START,
    S_WAIT_BUSY,
    S_WAIT_DONE,
    S_RESP
  } state_t;

  state_t            r_state;
  logic [GW-1:0]     r_last;
  logic [GW-1:0]     r_grant;
  logic [SW-1:0]     r_setup_cnt;
  logic [LEN_W-1:0]  r_len;
  logic [CS_W-1:0]   r_cs;
  logic [DIV_W-1:0]  r_div;
  logic [2:0]        r_mode;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_rdata;
  logic [NREQ-1:0]   r_resp_valid;
  logic              r_start;
  logic              r_busy;

`ifdef SPI_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0]     r_to_cnt;
  logic              r_err;
`endif

  logic              w_found;
  logic [GW-1:0]     w_grant;
  logic [GW:0]       w_sum;
  logic [GW:0]       w_idx;

  // Search upward from last+1, wrapping at NREQ.
  always_comb begin
    w_found = 1'b0;
    w_grant = '0;
    w_sum   = '0;
    w_idx   = '0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      w_sum = {1'b0, r_last} + (GW+1)'(k);
      w_idx = (w_sum >= (GW+1)'(NREQ)) ? w_sum - (GW+1)'(NREQ) : w_sum;
      if (!w_found && bus.req_valid[w_idx[GW-1:0]]) begin
        w_found = 1'b1;
        w_grant = w_idx[GW-1:0];
      end
    end
  end

  always_comb begin
    bus.req_ready = '0;
    if (r_state == S_IDLE && w_found) bus.req_ready[w_grant] = 1'b1;
  end

  // m_start is registered: its m_idle check is taken one cycle ahead (last CFG
  // cycle, then each START cycle) so the pulse lands inside START.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      r_state      <= S_IDLE;
      r_last       <= GW'(NREQ - 1);
      r_grant      <= '0;
      r_setup_cnt  <= '0;
      r_len        <= '0;
      r_cs         <= '0;
      r_div        <= '0;
      r_mode       <= '0;
      r_wdata      <= '0;
      r_rdata      <= '0;
      r_resp_valid <= '0;
      r_start      <= 1'b0;
      r_busy       <= 1'b0;
`ifdef SPI_ARB_TIMEOUT_EN
      r_to_cnt     <= '0;
      r_err        <= 1'b0;
`endif
    end else begin
      r_start      <= 1'b0;
      r_resp_valid <= '0;
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_grant     <= w_grant;
            r_wdata     <= bus.req_wdata[w_grant*DATA_W +: DATA_W];
            r_len       <= bus.req_len[w_grant*LEN_W +: LEN_W];
            r_cs        <= bus.req_cs[w_grant*CS_W +: CS_W];
            r_div       <= bus.req_div[w_grant*DIV_W +: DIV_W];
            r_mode      <= bus.req_mode[w_grant*3 +: 3];
            r_setup_cnt <= '0;
            r_busy      <= 1'b1;
            r_state     <= S_CFG;
          end
        end
        S_CFG: begin
          if (r_setup_cnt == SW'(SETUP_CYC - 1)) begin
            r_start <= bus.m_idle;
            r_state <= S_START;
`ifdef SPI_ARB_TIMEOUT_EN
            r_to_cnt <= '0;
`endif
          end else begin
            r_setup_cnt <= r_setup_cnt + 1'b1;
          end
        end
        S_START: begin
          if (r_start) r_state <= S_WAIT_BUSY;
          else         r_start <= bus.m_idle;
        end
        S_WAIT_BUSY: begin
          if (!bus.m_idle) r_state <= S_WAIT_DONE;
        end
        S_WAIT_DONE: begin
          if (bus.m_idle) begin
            r_rdata               <= bus.m_rdata;
            r_resp_valid[r_grant] <= 1'b1;
            r_state               <= S_RESP;
`ifdef SPI_ARB_TIMEOUT_EN
            r_err                 <= 1'b0;
`endif
          end
        end
        S_RESP: begin
          r_last  <= r_grant;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
`ifdef SPI_ARB_TIMEOUT_EN
      if (r_state == S_START || r_state == S_WAIT_BUSY || r_state == S_WAIT_DONE) begin
        if (r_to_cnt == TW'(TIMEOUT - 1)) begin
          r_start               <= 1'b0;
          r_rdata               <= '0;
          r_err                 <= 1'b1;
          r_resp_valid          <= '0;
          r_resp_valid[r_grant] <= 1'b1;
          r_state               <= S_RESP;
        end else begin
          r_to_cnt <= r_to_cnt + 1'b1;
        end
      end
`endif
    end
  end

  assign bus.m_len      = r_len;
  assign bus.m_cs       = r_cs;
  assign bus.m_div      = r_div;
  assign bus.m_mode     = r_mode;
  assign bus.m_wdata    = r_wdata;
  assign bus.m_start    = r_start;
  assign bus.resp_valid = r_resp_valid;
  assign bus.resp_rdata = r_rdata;
  assign bus.busy       = r_busy;
`ifdef SPI_ARB_TIMEOUT_EN
  assign bus.resp_err   = r_err;
`else
  assign bus.resp_err   = 1'b0;
`endif

endmodule

// File: tb/tb_spi_master_arb.sv
// Scoreboard bench for spi_master_arb: stimulus predicts round-robin grants and echoed
// rx words; one negedge process models the SPI engine and checks every DUT output event.
module tb_spi_master_arb;
  localparam int NREQ      = 2;
  localparam int DATA_W    = 16;
  localparam int LEN_W     = 5;
  localparam int CS_W      = 4;
  localparam int DIV_W     = 8;
  localparam int SETUP_CYC = 2;
  localparam int TIMEOUT   = 64;

  logic sys_clk   = 1'b0;
  logic sys_rst_n = 1'b0;

  spi_master_arb_if #(.NREQ(NREQ), .DATA_W(DATA_W), .LEN_W(LEN_W), .CS_W(CS_W),
                      .DIV_W(DIV_W)) bus ();

  spi_master_arb #(.NREQ(NREQ), .DATA_W(DATA_W), .LEN_W(LEN_W), .CS_W(CS_W),
                   .DIV_W(DIV_W), .SETUP_CYC(SETUP_CYC), .TIMEOUT(TIMEOUT)) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .bus       (bus)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct {
    int unsigned       grant;
    logic [DATA_W-1:0] rdata;
    logic              err;
    logic              chk_lat;
    logic [63:0]       cfg;
  } exp_t;

  exp_t q[$];

  // Requester field tables, written only by the stimulus.
  logic [DATA_W-1:0] f_wdata [NREQ];
  logic [LEN_W-1:0]  f_len   [NREQ];
  logic [CS_W-1:0]   f_cs    [NREQ];
  logic [DIV_W-1:0]  f_div   [NREQ];
  logic [2:0]        f_mode  [NREQ];

  // Reference arbitration state (stimulus only).
  int unsigned       ref_last;
  logic [DATA_W-1:0] ref_prev;

  // Stimulus -> monitor requests.
  int   hold_low_until = 0;
  bit   stuck_mode     = 1'b0;
  bit   end_req        = 1'b0;

  // Monitor-owned state.
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  int   n_grant = 0;
  int   n_resp = 0;
  int   n_start = 0;
  int   grant_cyc = 0;
  int   start_cyc = 0;
  int   starts_in_txn = 0;
  int   mm_busy = 0;
  bit   stuck_active = 1'b0;
  bit   pend_cfg = 1'b0;
  bit   rst_prev = 1'b0;
  bit   done = 1'b0;
  logic [DATA_W-1:0] mm_prev = '0;
  logic [DATA_W-1:0] mm_tx = '0;
  exp_t cur;

  always @(posedge sys_clk) cyc <= cyc + 1;

  function automatic logic [NREQ-1:0] oh(input int unsigned i);
    logic [NREQ-1:0] v;
    v = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  function automatic logic [63:0] pack_cfg(input logic [LEN_W-1:0] l, input logic [CS_W-1:0] c,
                                           input logic [DIV_W-1:0] d, input logic [2:0] m,
                                           input logic [DATA_W-1:0] w);
    return 64'({l, c, d, m, w});
  endfunction

  function void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endfunction

  // Engine model plus all output checks, sampled on the falling edge.
  always @(negedge sys_clk) begin
    if (!sys_rst_n) begin
      if (!rst_prev)
        chk("reset_state",
            64'({bus.busy, bus.resp_valid, bus.req_ready, bus.m_start, bus.resp_err,
                 bus.resp_rdata, bus.m_len, bus.m_cs, bus.m_div, bus.m_mode, bus.m_wdata}),
            64'd0);
      q.delete();
      mm_busy       = 0;
      mm_prev       = '0;
      stuck_active  = 1'b0;
      starts_in_txn = 0;
      pend_cfg      = 1'b0;
      bus.m_rdata   = '0;
    end else begin
      if (bus.req_ready != '0) begin
        if (q.size() == 0) chk("unexpected_grant", 64'(bus.req_ready), 64'd0);
        else               chk("grant_onehot", 64'(bus.req_ready), 64'(oh(q[0].grant)));
        n_grant++;
        grant_cyc     = cyc;
        starts_in_txn = 0;
        pend_cfg      = 1'b1;
      end else if (pend_cfg) begin
        pend_cfg = 1'b0;
        if (q.size() != 0)
          chk("cfg_at_grant", pack_cfg(bus.m_len, bus.m_cs, bus.m_div, bus.m_mode, bus.m_wdata),
              q[0].cfg);
      end

      if (bus.m_start) begin
        n_start++;
        starts_in_txn++;
        chk("start_while_engine_busy",
            64'({cyc < hold_low_until, mm_busy != 0, stuck_active}), 64'd0);
        if (q.size() != 0) begin
          chk("cfg_at_start", pack_cfg(bus.m_len, bus.m_cs, bus.m_div, bus.m_mode, bus.m_wdata),
              q[0].cfg);
          if (q[0].chk_lat) chk("start_latency", 64'(cyc - grant_cyc), 64'(SETUP_CYC + 1));
        end
        start_cyc = cyc;
        mm_tx     = bus.m_wdata;
        if (stuck_mode) stuck_active = 1'b1;
        else            mm_busy = int'($urandom_range(4, 9));
      end else if (mm_busy > 0) begin
        mm_busy--;
        if (mm_busy == 0) begin
          bus.m_rdata = mm_prev;
          mm_prev     = mm_tx;
        end
      end
      if (!stuck_mode) stuck_active = 1'b0;

      if (bus.resp_valid != '0) begin
        n_resp++;
        if (q.size() == 0) begin
          chk("unexpected_resp", 64'(bus.resp_valid), 64'd0);
        end else begin
          cur = q.pop_front();
          chk("resp_onehot", 64'(bus.resp_valid), 64'(oh(cur.grant)));
          chk("resp_rdata", 64'(bus.resp_rdata), 64'(cur.rdata));
          chk("resp_err", 64'(bus.resp_err), 64'(cur.err));
          chk("cfg_at_resp", pack_cfg(bus.m_len, bus.m_cs, bus.m_div, bus.m_mode, bus.m_wdata),
              cur.cfg);
          chk("start_count", 64'(starts_in_txn), 64'd1);
          if (cur.err) chk("timeout_cycles", 64'(cyc - start_cyc), 64'(TIMEOUT));
        end
      end

      if (end_req && !done) begin
        chk("outstanding_at_end", 64'(q.size()), 64'd0);
        done = 1'b1;
      end
    end
    rst_prev   = sys_rst_n;
    bus.m_idle = (mm_busy == 0) && (cyc >= hold_low_until) && !stuck_active;
  end

  task automatic drive(input logic [NREQ-1:0] mask);
    for (int i = 0; i < NREQ; i++) begin
      bus.req_wdata[i*DATA_W +: DATA_W] = f_wdata[i];
      bus.req_len[i*LEN_W +: LEN_W]     = f_len[i];
      bus.req_cs[i*CS_W +: CS_W]        = f_cs[i];
      bus.req_div[i*DIV_W +: DIV_W]     = f_div[i];
      bus.req_mode[i*3 +: 3]            = f_mode[i];
    end
    bus.req_valid = mask;
  endtask

  task automatic rand_fields();
    for (int i = 0; i < NREQ; i++) begin
      f_wdata[i] = DATA_W'($urandom);
      f_len[i]   = LEN_W'($urandom);
      f_cs[i]    = CS_W'($urandom);
      f_div[i]   = DIV_W'($urandom);
      f_mode[i]  = 3'($urandom);
    end
  endtask

  function automatic int unsigned rr_pick(input logic [NREQ-1:0] mask, input int unsigned last);
    int unsigned idx;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      idx = (last + k) % NREQ;
      if (mask[idx]) return idx;
    end
    return 0;
  endfunction

  task automatic issue(input logic [NREQ-1:0] mask, input bit hold, input bit stuck,
                       input bit chk_lat, input bit wait_resp);
    exp_t e;
    int   g0;
    int   r0;
    e.grant   = rr_pick(mask, ref_last);
    e.rdata   = stuck ? '0 : ref_prev;
    e.err     = stuck;
    e.chk_lat = chk_lat;
    e.cfg     = pack_cfg(f_len[e.grant], f_cs[e.grant], f_div[e.grant], f_mode[e.grant],
                         f_wdata[e.grant]);
    if (!stuck) ref_prev = f_wdata[e.grant];
    ref_last = e.grant;
    q.push_back(e);
    g0 = n_grant;
    r0 = n_resp;
    drive(mask);
    for (int c = 0; c < 100 && n_grant == g0; c++) begin
      @(posedge sys_clk); #1;
    end
    if (!hold) bus.req_valid = '0;
    if (wait_resp) begin
      for (int c = 0; c < 4 * TIMEOUT + 400 && n_resp == r0; c++) begin
        @(posedge sys_clk); #1;
      end
    end
  endtask

  task automatic apply_reset(input int cycles);
    sys_rst_n     = 1'b0;
    bus.req_valid = '0;
    repeat (cycles) begin
      @(posedge sys_clk); #1;
    end
    sys_rst_n = 1'b1;
    ref_last  = NREQ - 1;
    ref_prev  = '0;
  endtask

  initial begin
    int s0;
    for (int i = 0; i < NREQ; i++) begin
      f_wdata[i] = '0; f_len[i] = '0; f_cs[i] = '0; f_div[i] = '0; f_mode[i] = '0;
    end
    drive('0);
    apply_reset(3);

    // Warm-up from requester 1 so the next single request has a non-zero echo.
    rand_fields();
    issue(2'b10, 1'b0, 1'b0, 1'b1, 1'b1);

    f_wdata[0] = 16'hAA55; f_len[0] = 5'd15; f_cs[0] = 4'h1; f_div[0] = 8'd4; f_mode[0] = 3'b000;
    issue(2'b01, 1'b0, 1'b0, 1'b1, 1'b1);

    // Both requesters held continuously: grants alternate.
    rand_fields();
    for (int t = 0; t < 4; t++) issue(2'b11, t != 3, 1'b0, 1'b1, 1'b1);

    // Distinct configurations per requester.
    f_div[0] = 8'd4; f_mode[0] = 3'b000;
    f_div[1] = 8'd8; f_mode[1] = 3'b101;
    for (int t = 0; t < 3; t++) issue(2'b11, t != 2, 1'b0, 1'b1, 1'b1);

    // Engine busy at grant time.
    rand_fields();
    hold_low_until = cyc + 12;
    issue(2'b01, 1'b0, 1'b0, 1'b0, 1'b1);

    // Reset while waiting for the engine to finish.
    rand_fields();
    s0 = n_start;
    issue(2'b10, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int c = 0; c < 100 && n_start == s0; c++) begin
      @(posedge sys_clk); #1;
    end
    @(posedge sys_clk); #1;
    apply_reset(2);
    rand_fields();
    issue(2'b11, 1'b0, 1'b0, 1'b1, 1'b1);

`ifdef SPI_ARB_TIMEOUT_EN
    rand_fields();
    stuck_mode = 1'b1;
    issue(2'b01, 1'b0, 1'b1, 1'b1, 1'b1);
    stuck_mode = 1'b0;
    @(posedge sys_clk); #1;
`endif

    for (int t = 0; t < 30; t++) begin
      rand_fields();
      issue(NREQ'($urandom_range(1, (1 << NREQ) - 1)), 1'($urandom), 1'b0, 1'b1, 1'b1);
    end
    bus.req_valid = '0;

    repeat (5) begin
      @(posedge sys_clk); #1;
    end
    end_req = 1'b1;
    for (int c = 0; c < 10 && !done; c++) begin
      @(posedge sys_clk); #1;
    end
    if (!done) begin
      $display("FAIL end_handshake: got no final check, expected one");
      $fatal(1, "bench monitor stalled");
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
